// File: rtl/led_mm_cmd_master.sv
// Command/response front end that turns single read/write commands into
// Avalon-MM transactions toward the LED blinker controller, with a per-transaction timeout.
module led_mm_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_address,
    input  logic [31:0] cmd_writedata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_readdata,
    output logic        rsp_error,
    output logic        rsp_was_write,
    output logic [31:0] master_mm_address,
    output logic        master_mm_read,
    output logic        master_mm_write,
    output logic [31:0] master_mm_writedata,
    input  logic [31:0] master_mm_readdata,
    input  logic        master_mm_readdatavalid,
    input  logic        master_mm_waitrequest,
    output logic        master_rst
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RESP
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                cmd_ready_d;
    logic                rsp_valid_d;
    logic                rsp_error_d;
    logic                rsp_was_write_d;
    logic [DATA_W-1:0]   rsp_readdata_d;
    logic [ADDR_W-1:0]   mm_address_d;
    logic [DATA_W-1:0]   mm_writedata_d;
    logic                mm_read_d;
    logic                mm_write_d;
    logic                accept;
    logic                timeout;

    assign accept  = cmd_valid & cmd_ready;
    assign timeout = (cnt_q >= CNT_LAST);

    // State register plus registered copies of every output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            cmd_ready           <= 1'b0;
            rsp_valid           <= 1'b0;
            rsp_error           <= 1'b0;
            rsp_was_write       <= 1'b0;
            rsp_readdata        <= '0;
            master_mm_address   <= '0;
            master_mm_writedata <= '0;
            master_mm_read      <= 1'b0;
            master_mm_write     <= 1'b0;
            master_rst          <= 1'b1;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            cmd_ready           <= cmd_ready_d;
            rsp_valid           <= rsp_valid_d;
            rsp_error           <= rsp_error_d;
            rsp_was_write       <= rsp_was_write_d;
            rsp_readdata        <= rsp_readdata_d;
            master_mm_address   <= mm_address_d;
            master_mm_writedata <= mm_writedata_d;
            master_mm_read      <= mm_read_d;
            master_mm_write     <= mm_write_d;
            master_rst          <= 1'b0;
        end
    end

    // Next state and next output values; completion is tested before timeout so it wins ties
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cmd_ready_d     = 1'b0;
        rsp_valid_d     = rsp_valid;
        rsp_error_d     = rsp_error;
        rsp_was_write_d = rsp_was_write;
        rsp_readdata_d  = rsp_readdata;
        mm_address_d    = master_mm_address;
        mm_writedata_d  = master_mm_writedata;
        mm_read_d       = 1'b0;
        mm_write_d      = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_d = ~accept;
                if (accept) begin
                    cnt_d           = '0;
                    mm_address_d    = cmd_address;
                    mm_writedata_d  = cmd_writedata;
                    rsp_was_write_d = cmd_write;
                    rsp_error_d     = 1'b0;
                    rsp_readdata_d  = '0;
                    if (cmd_write) begin
                        state_d    = WR;
                        mm_write_d = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        mm_read_d = 1'b1;
                    end
                end
            end
            WR: begin
                cnt_d = cnt_q + 16'd1;
                if (!master_mm_waitrequest || timeout) begin
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_error_d    = master_mm_waitrequest;
                    rsp_readdata_d = '0;
                end else begin
                    mm_write_d = 1'b1;
                end
            end
            RD_REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (!master_mm_waitrequest) begin
                    state_d = RD_WAIT;
                end else if (timeout) begin
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_error_d    = 1'b1;
                    rsp_readdata_d = '0;
                end else begin
                    mm_read_d = 1'b1;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (master_mm_readdatavalid) begin
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_error_d    = 1'b0;
                    rsp_readdata_d = master_mm_readdata;
                end else if (timeout) begin
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_error_d    = 1'b1;
                    rsp_readdata_d = '0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
